mem_responder: RTL and testbench

Cache-side responder for the datapath/cache interface. It serves the datapath's instruction-fetch and data-access requests against a single-ported word RAM that uses a ready handshake. It arbitrates the two request streams, with data taking priority, and returns registered load data with one-cycle ihit/dhit pulses. On datapath halt it parks in a sticky halted state.

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Cache-side responder: arbitrates datapath fetch and data requests onto a single-ported,
// ready-handshaked word RAM and returns registered load data with one-cycle hit pulses.
module mem_responder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic [DATA_W-1:0] imemload,
    output logic              ihit,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [DATA_W-1:0] dmemstore,
    output logic [DATA_W-1:0] dmemload,
    output logic              dhit,
    input  logic              halt,
    output logic              halted,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StDacc,
        StDresp,
        StIacc,
        StIresp,
        StHalted
    } state_e;

    state_e state;
    logic   op_write;

    // Byte-offset bits are dropped by design; no misalignment error exists.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= StIdle;
            op_write  <= 1'b0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            halted    <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            imemload  <= '0;
            dmemload  <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                StIdle: begin
                    if (halt) begin
                        state  <= StHalted;
                        halted <= 1'b1;
                    end else if (dmemWEN || dmemREN) begin
                        state     <= StDacc;
                        op_write  <= dmemWEN;
                        ram_addr  <= {dmemaddr[ADDR_W-1:2], 2'b00};
                        ram_wdata <= dmemstore;
                        ram_wen   <= dmemWEN;
                        ram_ren   <= ~dmemWEN;
                    end else if (imemREN) begin
                        state    <= StIacc;
                        op_write <= 1'b0;
                        ram_addr <= {imemaddr[ADDR_W-1:2], 2'b00};
                        ram_wen  <= 1'b0;
                        ram_ren  <= 1'b1;
                    end
                end

                StDacc: begin
                    if (ram_ready) begin
                        if (!op_write) begin
                            dmemload <= ram_rdata;
                        end
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        // A withdrawn request still completes on the RAM but earns no hit.
                        if (dmemREN || dmemWEN) begin
                            state <= StDresp;
                            dhit  <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end

                StDresp: begin
                    state <= StIdle;
                end

                StIacc: begin
                    if (ram_ready) begin
                        imemload <= ram_rdata;
                        ram_ren  <= 1'b0;
                        ram_wen  <= 1'b0;
                        if (imemREN) begin
                            state <= StIresp;
                            ihit  <= 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end

                StIresp: begin
                    state <= StIdle;
                end

                StHalted: begin
                    halted  <= 1'b1;
                    ram_ren <= 1'b0;
                    ram_wen <= 1'b0;
                end

                default: begin
                    state   <= StIdle;
                    ram_ren <= 1'b0;
                    ram_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder: a word-memory reference model predicts every
// hit, a behavioural RAM answers with random wait states, and a monitor checks each hit.
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic [31:0] imemload;
    logic        ihit;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemstore = '0;
    logic [31:0] dmemload;
    logic        dhit;
    logic        halt = 1'b0;
    logic        halted;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        ram_ready = 1'b0;

    mem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmemload(dmemload), .dhit(dhit), .halt(halt), .halted(halted),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Untouched words hold an address-dependent pattern so a wrong RAM address shows up as bad data.
    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w, 2'b01} * 32'h9E3779B1 + 32'h01234567;
    endfunction

    logic [31:0] ram_mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] last_dload = '0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return init_word(a[31:2]);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ram_mem[a[31:2]] = d;
        ref_mem[a[31:2]] = d;
    endtask

    // Behavioural RAM: ready after a programmable number of wait cycles, plus stray ready pulses
    // while idle that the responder must ignore.
    int fixed_wait = 0;
    int ram_wait = 0;

    function automatic int next_wait();
        if (fixed_wait >= 0) return fixed_wait;
        return int'($urandom_range(3));
    endfunction

    always @(negedge CLK) begin
        logic [29:0] w;
        ram_ready = 1'b0;
        ram_rdata = $urandom;
        if (ram_ren === 1'b1 || ram_wen === 1'b1) begin
            if (ram_wait == 0) begin
                w = ram_addr[31:2];
                if (!ram_mem.exists(w)) ram_mem[w] = init_word(w);
                ram_ready = 1'b1;
                ram_rdata = ram_mem[w];
                if (ram_wen) ram_mem[w] = ram_wdata;
                ram_wait = next_wait();
            end else begin
                ram_wait--;
            end
        end else if ($urandom_range(3) == 0) begin
            ram_ready = 1'b1;
        end
    end

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];

    always @(negedge CLK) begin
        exp_t e;
        if (ihit === 1'b1 && dhit === 1'b1) check("hit_overlap", {30'b0, ihit, dhit}, 32'h0);
        if (ihit === 1'b1 || dhit === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_hit: got ihit=%0b dhit=%0b expected no hit", ihit, dhit);
            end else begin
                e = sbq.pop_front();
                check("hit_kind", {30'b0, ihit, dhit}, e.is_d ? 32'h1 : 32'h2);
                if (e.is_d) check("dmemload", dmemload, e.data);
                else        check("imemload", imemload, e.data);
            end
        end
    end

    task automatic wait_hits(input bit wi, input bit wd);
        bit pi = wi;
        bit pd = wd;
        int n = 0;
        while ((pi || pd) && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (dhit) begin pd = 0; dmemREN = 1'b0; dmemWEN = 1'b0; end
            if (ihit) begin pi = 0; imemREN = 1'b0; end
        end
        if (pi || pd) begin
            total++;
            bad++;
            $display("FAIL hit_timeout: pending i=%0d d=%0d expected none", pi, pd);
            imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        end
    endtask

    task automatic run_txn(input bit di, input bit dd, input bit dw,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] sd);
        exp_t e;
        if (dd) begin
            if (dw) ref_mem[da[31:2]] = sd;
            else    last_dload = ref_rd(da);
            e.is_d = 1'b1; e.data = last_dload; sbq.push_back(e);
        end
        if (di) begin
            e.is_d = 1'b0; e.data = ref_rd(ia); sbq.push_back(e);
        end
        imemREN   = di;
        imemaddr  = ia;
        dmemWEN   = dd & dw;
        dmemREN   = dd & (dw ? 1'($urandom_range(1)) : 1'b1);
        dmemaddr  = da;
        dmemstore = sd;
        wait_hits(di, dd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        int ren_seen;
        logic [31:0] ia, da;
        int kind;

        // Reset held with a fetch pending.
        imemREN = 1'b1;
        imemaddr = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ihit", {31'b0, ihit}, 32'h0);
        check("rst_dhit", {31'b0, dhit}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_ram_ren", {31'b0, ram_ren}, 32'h0);
        check("rst_ram_wen", {31'b0, ram_wen}, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        check("rst_dmemload", dmemload, 32'h0);
        e.is_d = 1'b0; e.data = ref_rd(32'h0); sbq.push_back(e);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_ram_ren", {31'b0, ram_ren}, 32'h1);
        check("post_rst_ram_addr", ram_addr, 32'h0);
        wait_hits(1, 0);
        @(posedge CLK); #1;

        // Fetch from an unaligned address with two RAM wait cycles.
        preload(32'h44, 32'h8C220004);
        fixed_wait = 2;
        ram_wait = 2;
        e.is_d = 1'b0; e.data = 32'h8C220004; sbq.push_back(e);
        imemREN = 1'b1;
        imemaddr = 32'h47;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
            if (n == 1) begin
                check("fetch_ram_addr", ram_addr, 32'h44);
                check("fetch_ram_ren", {31'b0, ram_ren}, 32'h1);
            end
        end while (!ihit && n < 20);
        check("fetch_latency", n, 32'd4);
        imemREN = 1'b0;
        @(posedge CLK); #1;

        // Load and fetch together on a zero-wait RAM: data first, then fetch.
        fixed_wait = 0;
        ram_wait = 0;
        preload(32'h100, 32'hDEADBEEF);
        preload(32'h8, 32'h00000020);
        run_txn(1, 1, 0, 32'h8, 32'h100, 32'h0);
        @(posedge CLK); #1;

        // Store with both strobes raised and one wait cycle.
        fixed_wait = 1;
        ram_wait = 1;
        ref_mem[32'h200 >> 2] = 32'h12345678;
        e.is_d = 1'b1; e.data = last_dload; sbq.push_back(e);
        dmemWEN = 1'b1;
        dmemREN = 1'b1;
        dmemaddr = 32'h200;
        dmemstore = 32'h12345678;
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK);
            #1;
            check("store_ram_wen", {31'b0, ram_wen}, 32'h1);
            check("store_ram_ren", {31'b0, ram_ren}, 32'h0);
            check("store_ram_wdata", ram_wdata, 32'h12345678);
        end
        wait_hits(0, 1);
        check("store_dmemload_kept", dmemload, 32'hDEADBEEF);
        run_txn(0, 1, 0, 32'h0, 32'h200, 32'h0);

        // Fetch withdrawn before ram_ready: no ihit, data still captured.
        fixed_wait = 3;
        ram_wait = 3;
        preload(32'h30, 32'hCAFEF00D);
        imemREN = 1'b1;
        imemaddr = 32'h30;
        repeat (2) @(posedge CLK);
        #1;
        imemREN = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("abort_ram_ren", {31'b0, ram_ren}, 32'h0);
        check("abort_imemload", imemload, 32'hCAFEF00D);
        run_txn(1, 0, 0, 32'h44, 32'h0, 32'h0);

        // Randomised mix over a small shared region so stores feed later loads and fetches.
        fixed_wait = -1;
        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(4));
            ia = 32'h400 | ({28'b0, 4'($urandom_range(15))} << 2) | {30'b0, 2'($urandom_range(3))};
            da = 32'h400 | ({28'b0, 4'($urandom_range(15))} << 2) | {30'b0, 2'($urandom_range(3))};
            case (kind)
                0: run_txn(1, 0, 0, ia, da, $urandom);
                1: run_txn(0, 1, 0, ia, da, $urandom);
                2: run_txn(0, 1, 1, ia, da, $urandom);
                3: run_txn(1, 1, 0, ia, da, $urandom);
                default: run_txn(1, 1, 1, ia, da, $urandom);
            endcase
            repeat ($urandom_range(2)) @(posedge CLK);
            #1;
        end

        // Halt raised mid-access: the load still completes, then the responder parks.
        fixed_wait = 0;
        ram_wait = 0;
        @(posedge CLK); #1;
        last_dload = ref_rd(32'h100);
        e.is_d = 1'b1; e.data = last_dload; sbq.push_back(e);
        dmemREN = 1'b1;
        dmemaddr = 32'h100;
        @(posedge CLK);
        #1;
        halt = 1'b1;
        wait_hits(0, 1);
        repeat (3) @(posedge CLK);
        #1;
        check("halted_set", {31'b0, halted}, 32'h1);
        imemREN = 1'b1;
        imemaddr = 32'h8;
        ren_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK);
            #1;
            if (ram_ren || ram_wen) ren_seen++;
        end
        check("halted_no_strobe", ren_seen, 32'd0);
        check("halted_sticky", {31'b0, halted}, 32'h1);
        nRST = 1'b0;
        halt = 1'b0;
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        check("halted_cleared", {31'b0, halted}, 32'h0);
        nRST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
